// File: rtl/param_cpu_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | param_cpu_core : 8-bit-ISA phase-sequenced core, DATA_W/PC_W wide     |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module param_cpu_core #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [7:0]        imem_data,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        dbg_phase,
  output logic [PC_W-1:0]   dbg_pc
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    WAIT_IN   = 3'd3,
    WAIT_OUT  = 3'd4,
    WRITEBACK = 3'd5
  } state_t;

  localparam logic [1:0] OP_LI   = 2'b00;
  localparam logic [1:0] OP_ALU  = 2'b01;
  localparam logic [1:0] OP_COPY = 2'b10;
  localparam logic [1:0] OP_JMP  = 2'b11;
  localparam logic [2:0] CODE_IO = 3'd6;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [7:0]          ir_q, ir_d;
  logic [DATA_W-1:0]   regs_q [6];
  logic [DATA_W-1:0]   regs_d [6];
  logic [DATA_W-1:0]   in_word_q, in_word_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;

  logic [1:0]          op;
  logic [2:0]          op_a, op_b;
  logic [DATA_W-1:0]   reg_a, copy_src, alu_res, r1, r2, r3;
  logic [PC_W-1:0]     pc_inc, jmp_target;
  logic                r3_zero, r3_neg, jmp_taken;

  assign op         = ir_q[7:6];
  assign op_a       = ir_q[5:3];
  assign op_b       = ir_q[2:0];
  assign r1         = regs_q[1];
  assign r2         = regs_q[2];
  assign r3         = regs_q[3];
  assign pc_inc     = pc_q + PC_W'(1);
  assign jmp_target = PC_W'(regs_q[0]);
  assign copy_src   = (op_a == CODE_IO) ? in_word_q : reg_a;

  // Codes 6 and 7 read as zero here; the I/O word is selected separately.
  always_comb begin
    reg_a = '0;
    for (int i = 0; i < 6; i++) begin
      if (op_a == 3'(i)) reg_a = regs_q[i];
    end
  end

  always_comb begin
    alu_res = '0;
    case (op_b)
      3'd0: alu_res = r1 | r2;
      3'd1: alu_res = ~(r1 & r2);
      3'd2: alu_res = ~(r1 | r2);
      3'd3: alu_res = r1 & r2;
      3'd4: alu_res = r1 + r2;
      3'd5: alu_res = r1 - r2;
      3'd6: alu_res = r1 ^ r2;
      3'd7: alu_res = ~(r1 ^ r2);
      default: alu_res = '0;
    endcase
  end

  assign r3_zero = (r3 == '0);
  assign r3_neg  = r3[DATA_W-1];

  always_comb begin
    jmp_taken = 1'b0;
    case (op_b)
      3'd0: jmp_taken = 1'b0;
      3'd1: jmp_taken = r3_zero;
      3'd2: jmp_taken = r3_neg;
      3'd3: jmp_taken = r3_neg | r3_zero;
      3'd4: jmp_taken = 1'b1;
      3'd5: jmp_taken = ~r3_zero;
      3'd6: jmp_taken = ~r3_neg;
      3'd7: jmp_taken = ~r3_neg & ~r3_zero;
      default: jmp_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    regs_d      = regs_q;
    in_word_d   = in_word_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (enable) begin
      case (state_q)
        FETCH: state_d = DECODE;
        DECODE: begin
          ir_d    = imem_data;
          state_d = EXECUTE;
        end
        EXECUTE: begin
          if (op == OP_COPY && op_a == CODE_IO) begin
            in_ready_d = 1'b1;
            state_d    = WAIT_IN;
          end else if (op == OP_COPY && op_b == CODE_IO) begin
            out_data_d  = reg_a;
            out_valid_d = 1'b1;
            state_d     = WAIT_OUT;
          end else begin
            state_d = WRITEBACK;
          end
        end
        WAIT_IN: begin
          if (in_valid && in_ready_q) begin
            in_word_d  = in_data;
            in_ready_d = 1'b0;
            if (op_b == CODE_IO) begin
              out_data_d  = in_data;
              out_valid_d = 1'b1;
              state_d     = WAIT_OUT;
            end else begin
              state_d = WRITEBACK;
            end
          end
        end
        WAIT_OUT: begin
          if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            state_d     = WRITEBACK;
          end
        end
        WRITEBACK: begin
          state_d = FETCH;
          pc_d    = pc_inc;
          case (op)
            OP_LI:  regs_d[0] = DATA_W'(ir_q[5:0]);
            OP_ALU: regs_d[3] = alu_res;
            OP_COPY: begin
              for (int i = 0; i < 6; i++) begin
                if (op_b == 3'(i)) regs_d[i] = copy_src;
              end
            end
            OP_JMP: if (jmp_taken) pc_d = jmp_target;
            default: ;
          endcase
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      for (int i = 0; i < 6; i++) regs_q[i] <= '0;
      in_word_q   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      regs_q      <= regs_d;
      in_word_q   <= in_word_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign imem_addr = pc_q;
  assign dbg_pc    = pc_q;
  assign dbg_phase = state_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_param_cpu_core.sv
`default_nettype none
// tb_param_cpu_core : vector tables plus scoreboarded I/O handshakes.
module tb_param_cpu_core;
  localparam int DW = 16;
  localparam int PW = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, enable;
  logic [PW-1:0] imem_addr, dbg_pc;
  logic [7:0]    imem_data;
  logic [DW-1:0] in_data, out_data;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [2:0]    dbg_phase;
  logic [7:0]    imem [256];

  assign imem_data = imem[imem_addr];

  param_cpu_core #(.DATA_W(DW), .PC_W(PW)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .dbg_phase(dbg_phase), .dbg_pc(dbg_pc)
  );

  // Narrow-PC instance used only for the wrap check.
  logic       reset2;
  logic [3:0] addr2, pc2;
  logic [7:0] in2, out2;
  logic       in_rdy2, out_vld2;
  logic [2:0] phase2;

  param_cpu_core #(.DATA_W(8), .PC_W(4)) dut2 (
    .clock(clock), .reset(reset2), .enable(1'b1),
    .imem_addr(addr2), .imem_data(8'h01),
    .in_data(8'h00), .in_valid(1'b0), .in_ready(in_rdy2),
    .out_data(out2), .out_valid(out_vld2), .out_ready(1'b0),
    .dbg_phase(phase2), .dbg_pc(pc2)
  );

  int checks = 0;
  int passed = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] in_q[$];
  int            in_lat, out_lat, in_wait, out_wait, last_hold;
  bit            out_force;
  logic [DW-1:0] held_data;

  typedef struct { logic [2:0] fn; logic [15:0] a; logic [15:0] b; logic [15:0] exp; } alu_vec_t;
  typedef struct { logic [15:0] r3; logic [2:0] cond; logic [7:0] exp_pc; } jmp_vec_t;
  alu_vec_t alu_tab[9];
  jmp_vec_t jmp_tab[13];
  logic [2:0] ph_exp[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive_io();
    in_valid  = (in_q.size() > 0) && (in_wait >= in_lat);
    in_data   = (in_q.size() > 0) ? in_q[0] : '0;
    out_ready = out_force || (out_wait >= out_lat);
  endtask

  // One clock: observe at the falling edge, update stimulus just after the rising edge.
  task automatic cycle();
    bit consumed;
    @(negedge clock);
    consumed = 1'b0;
    check("no_dual_handshake", {31'b0, in_ready & out_valid}, 32'd0);
    if (reset && enable && in_valid && in_ready) consumed = 1'b1;
    if (reset && out_valid) begin
      if (out_wait > 0) check("out_stable", out_data, held_data);
      else held_data = out_data;
      if (enable && out_ready) begin
        last_hold = out_wait;
        out_wait  = 0;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL out_unexpected: got 0x%0h, no word expected", out_data);
        end else begin
          check("out_word", out_data, exp_q.pop_front());
        end
      end else begin
        out_wait++;
      end
    end
    if (reset && in_ready && !consumed) in_wait++;
    @(posedge clock);
    #1;
    if (consumed) begin
      void'(in_q.pop_front());
      in_wait = 0;
    end
    drive_io();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    exp_q.delete();
    in_q.delete();
    in_wait = 0; out_wait = 0; in_lat = 0; out_lat = 0; out_force = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    cycle();
    cycle();
    reset = 1'b1;
    drive_io();
  endtask

  task automatic run_to(input logic [PW-1:0] target, input int budget);
    int n = 0;
    while (!(dbg_phase == 3'd0 && dbg_pc >= target) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) begin
      checks++;
      $display("FAIL run_to timeout: pc 0x%0h, required 0x%0h", dbg_pc, target);
    end
  endtask

  task automatic wait_phase(input logic [2:0] ph, input int budget);
    int n = 0;
    while (dbg_phase != ph && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) begin
      checks++;
      $display("FAIL wait_phase timeout: phase %0d, required %0d", dbg_phase, ph);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    alu_tab[0] = '{3'd0, 16'h00F0, 16'h0F0F, 16'h0FFF};
    alu_tab[1] = '{3'd1, 16'hFF00, 16'h0FF0, 16'hF0FF};
    alu_tab[2] = '{3'd2, 16'h1200, 16'h0034, 16'hEDCB};
    alu_tab[3] = '{3'd3, 16'hABCD, 16'h0FF0, 16'h0BC0};
    alu_tab[4] = '{3'd4, 16'hFFFF, 16'h0002, 16'h0001};
    alu_tab[5] = '{3'd5, 16'h0001, 16'h0002, 16'hFFFF};
    alu_tab[6] = '{3'd6, 16'hAAAA, 16'h0F0F, 16'hA5A5};
    alu_tab[7] = '{3'd7, 16'h1234, 16'h1234, 16'hFFFF};
    alu_tab[8] = '{3'd4, 16'h7FFF, 16'h0001, 16'h8000};
    jmp_tab[0]  = '{16'hFFFF, 3'd2, 8'h20};
    jmp_tab[1]  = '{16'hFFFF, 3'd7, 8'h03};
    jmp_tab[2]  = '{16'h0000, 3'd1, 8'h20};
    jmp_tab[3]  = '{16'h0000, 3'd5, 8'h03};
    jmp_tab[4]  = '{16'h0005, 3'd7, 8'h20};
    jmp_tab[5]  = '{16'h0005, 3'd3, 8'h03};
    jmp_tab[6]  = '{16'h0000, 3'd3, 8'h20};
    jmp_tab[7]  = '{16'h8000, 3'd6, 8'h03};
    jmp_tab[8]  = '{16'h0000, 3'd6, 8'h20};
    jmp_tab[9]  = '{16'h0007, 3'd0, 8'h03};
    jmp_tab[10] = '{16'h0007, 3'd4, 8'h20};
    jmp_tab[11] = '{16'hFFFF, 3'd5, 8'h20};
    jmp_tab[12] = '{16'h8000, 3'd3, 8'h20};
    ph_exp = '{3'd0, 3'd1, 3'd2, 3'd5};

    reset = 1'b0; reset2 = 1'b0; enable = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_lat = 0; out_lat = 0; in_wait = 0; out_wait = 0; last_hold = 0;
    out_force = 1'b0; held_data = '0;

    // Reset values and the four-phase sequence over two load-immediates.
    do_reset();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    imem[0] = 8'h05; imem[1] = 8'h3F; imem[2] = 8'h86;
    for (int i = 0; i < 8; i++) begin
      check("phase_seq", dbg_phase, ph_exp[i % 4]);
      check("pc_seq", dbg_pc, i / 4);
      cycle();
    end
    check("pc_after_two", dbg_pc, 32'd2);
    exp_q.push_back(16'h003F);
    run_to(3, 40);
    check("sb_drained_li", exp_q.size(), 32'd0);

    // ALU table: r1, r2 from the input port, result r3 sent out.
    foreach (alu_tab[k]) begin
      do_reset();
      imem[0] = 8'hB1; imem[1] = 8'hB2; imem[2] = {5'b01000, alu_tab[k].fn}; imem[3] = 8'h9E;
      in_q.push_back(alu_tab[k].a);
      in_q.push_back(alu_tab[k].b);
      exp_q.push_back(alu_tab[k].exp);
      drive_io();
      run_to(4, 80);
      check("alu_sb_drained", exp_q.size(), 32'd0);
    end

    // Jump table: r3 from input, r0 = 0x20, conditional jump at address 2.
    foreach (jmp_tab[k]) begin
      do_reset();
      imem[0] = 8'hB3; imem[1] = 8'h20; imem[2] = {5'b11000, jmp_tab[k].cond};
      in_q.push_back(jmp_tab[k].r3);
      drive_io();
      run_to(3, 60);
      check("jump_pc", dbg_pc, jmp_tab[k].exp_pc);
    end

    // Output stall: sink holds off for five observed cycles.
    do_reset();
    imem[0] = 8'h2A; imem[1] = 8'h86;
    out_lat = 5;
    exp_q.push_back(16'h002A);
    drive_io();
    run_to(2, 60);
    check("out_hold_cycles", last_hold, 32'd5);
    check("out_stall_pc", dbg_pc, 32'd2);
    check("out_stall_drained", exp_q.size(), 32'd0);

    // Late input into r4, then r4 to the output port.
    do_reset();
    imem[0] = 8'hB4; imem[1] = 8'hA6;
    in_lat = 3;
    in_q.push_back(16'h0099);
    exp_q.push_back(16'h0099);
    drive_io();
    wait_phase(3'd2, 20);
    cycle();
    check("in_ready_after_exec", {31'b0, in_ready}, 32'd1);
    check("wait_in_phase", dbg_phase, 32'd3);
    run_to(2, 60);
    check("in_late_drained", exp_q.size(), 32'd0);

    // Input straight to output with in_valid raised before in_ready.
    do_reset();
    imem[0] = 8'hB6;
    in_q.push_back(16'h0077);
    exp_q.push_back(16'h0077);
    drive_io();
    run_to(1, 60);
    check("in_out_drained", exp_q.size(), 32'd0);
    check("in_out_consumed", in_q.size(), 32'd0);

    // enable low freezes EXECUTE and blocks a WAIT_OUT transfer.
    do_reset();
    imem[0] = 8'h2A; imem[1] = 8'h86;
    out_lat = 100;
    exp_q.push_back(16'h002A);
    drive_io();
    wait_phase(3'd2, 20);
    enable = 1'b0;
    repeat (10) cycle();
    check("frozen_phase", dbg_phase, 32'd2);
    check("frozen_pc", dbg_pc, 32'd0);
    enable = 1'b1;
    wait_phase(3'd4, 40);
    enable = 1'b0;
    out_force = 1'b1;
    drive_io();
    repeat (3) cycle();
    check("gated_wait_out", dbg_phase, 32'd4);
    check("gated_out_valid", {31'b0, out_valid}, 32'd1);
    check("gated_not_taken", exp_q.size(), 32'd1);
    enable = 1'b1;
    run_to(2, 40);
    check("gated_drained", exp_q.size(), 32'd0);

    // Reset while stalled in WAIT_OUT.
    do_reset();
    imem[0] = 8'h2A; imem[1] = 8'h86;
    out_lat = 100;
    drive_io();
    wait_phase(3'd4, 40);
    reset = 1'b0;
    exp_q.delete();
    cycle();
    check("rst_wo_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_wo_pc", dbg_pc, 32'd0);
    check("rst_wo_phase", dbg_phase, 32'd0);
    reset = 1'b1;

    // Reset while stalled in WAIT_IN.
    do_reset();
    imem[0] = 8'hB4;
    in_lat = 100;
    in_q.push_back(16'h0055);
    drive_io();
    wait_phase(3'd3, 40);
    check("wait_in_ready", {31'b0, in_ready}, 32'd1);
    reset = 1'b0;
    in_q.delete();
    cycle();
    check("rst_wi_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_wi_phase", dbg_phase, 32'd0);

    // Four-bit PC wraps from 15 to 0 on straight-line code.
    reset = 1'b0;
    reset2 = 1'b0;
    cycle();
    cycle();
    reset2 = 1'b1;
    repeat (60) cycle();
    check("wrap_pc15", pc2, 32'd15);
    check("wrap_phase15", phase2, 32'd0);
    repeat (4) cycle();
    check("wrap_pc0", pc2, 32'd0);
    check("wrap_phase0", phase2, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
